// File: rtl/id_stage_hz.sv
// rtl/id_stage_hz.sv - RV32I/RV64I decode stage with WB bypass, load-use bubbles and ID/EX register
module id_stage_hz #(
  parameter int XLEN      = 32,
  parameter bit WB_BYPASS = 1'b1,
  parameter bit HAZARD_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_id_valid,
  input  logic [XLEN-1:0]  if_id_pc,
  input  logic [31:0]      if_id_instruction,
  input  logic             flush,
  input  logic             ex_stall,
  output logic             id_ready,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [4:0]       mem_wb_rd_addr,
  input  logic [XLEN-1:0]  mem_wb_rd_data,
  input  logic             mem_wb_reg_write,
  output logic [XLEN-1:0]  id_ex_pc,
  output logic [31:0]      id_ex_instruction,
  output logic [XLEN-1:0]  id_ex_rs1_data,
  output logic [XLEN-1:0]  id_ex_rs2_data,
  output logic [XLEN-1:0]  id_ex_immediate,
  output logic [4:0]       id_ex_rd_addr,
  output logic [4:0]       id_ex_rs1_addr,
  output logic [4:0]       id_ex_rs2_addr,
  output logic             id_ex_reg_write,
  output logic             id_ex_mem_read,
  output logic             id_ex_mem_write,
  output logic             id_ex_alu_src,
  output logic             id_ex_branch,
  output logic             id_ex_jump,
  output logic [3:0]       id_ex_alu_op,
  output logic             id_ex_illegal,
  output logic             id_ex_valid,
  output logic [CNT_W-1:0] hazard_count
);

  // Base opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU operation codes seen by EX
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Immediate formats
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_addr;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic [3:0]      alu_op;
    logic            illegal;
    logic            valid;
  } idex_t;

  idex_t            idex_q, idex_d, dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt_bit;
  logic [4:0]  rs1_field, rs2_field, rd_field;

  logic        use_rs1, use_rs2, rd_zero;
  logic [2:0]  imm_sel;
  logic        ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_alu_src, ctl_branch, ctl_jump;
  logic [3:0]  ctl_alu_op;
  logic        ctl_illegal;

  logic signed [31:0] imm32;
  logic [XLEN-1:0]    rs1_val, rs2_val;
  logic               hazard;

  assign opcode    = if_id_instruction[6:0];
  assign rd_field  = if_id_instruction[11:7];
  assign funct3    = if_id_instruction[14:12];
  assign rs1_field = if_id_instruction[19:15];
  assign rs2_field = if_id_instruction[24:20];
  assign alt_bit   = if_id_instruction[30];

  // Register file is addressed straight from the raw fields so the read overlaps decode
  assign rs1_addr = rs1_field;
  assign rs2_addr = rs2_field;

  // funct3 to ALU op for register and immediate arithmetic; SUB exists only for OP
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt,
                                                 input logic is_op);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && is_op) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Opcode decode into operand usage, immediate format and control bits
  always_comb begin
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    rd_zero       = 1'b0;
    imm_sel       = IMM_NONE;
    ctl_reg_write = 1'b0;
    ctl_mem_read  = 1'b0;
    ctl_mem_write = 1'b0;
    ctl_alu_src   = 1'b0;
    ctl_branch    = 1'b0;
    ctl_jump      = 1'b0;
    ctl_alu_op    = ALU_ADD;
    ctl_illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        ctl_reg_write = 1'b1;
        ctl_alu_op    = alu_from_funct3(funct3, alt_bit, 1'b1);
      end
      OPC_OP_IMM: begin
        use_rs1       = 1'b1;
        imm_sel       = IMM_I;
        ctl_reg_write = 1'b1;
        ctl_alu_src   = 1'b1;
        ctl_alu_op    = alu_from_funct3(funct3, alt_bit, 1'b0);
      end
      OPC_LOAD: begin
        use_rs1       = 1'b1;
        imm_sel       = IMM_I;
        ctl_reg_write = 1'b1;
        ctl_mem_read  = 1'b1;
        ctl_alu_src   = 1'b1;
      end
      OPC_STORE: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        rd_zero       = 1'b1;
        imm_sel       = IMM_S;
        ctl_mem_write = 1'b1;
        ctl_alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        rd_zero       = 1'b1;
        imm_sel       = IMM_B;
        ctl_branch    = 1'b1;
        ctl_alu_op    = ALU_SUB;
      end
      OPC_JAL: begin
        imm_sel       = IMM_J;
        ctl_reg_write = 1'b1;
        ctl_jump      = 1'b1;
      end
      OPC_JALR: begin
        use_rs1       = 1'b1;
        imm_sel       = IMM_I;
        ctl_reg_write = 1'b1;
        ctl_jump      = 1'b1;
      end
      OPC_LUI: begin
        imm_sel       = IMM_U;
        ctl_reg_write = 1'b1;
        ctl_alu_src   = 1'b1;
        ctl_alu_op    = ALU_PASSB;
      end
      OPC_AUIPC: begin
        imm_sel       = IMM_U;
        ctl_reg_write = 1'b1;
        ctl_alu_src   = 1'b1;
      end
      default: ctl_illegal = 1'b1;
    endcase
  end

  // Immediate assembly; every format fits in 32 signed bits and is widened to XLEN below
  always_comb begin
    imm32 = '0;
    case (imm_sel)
      IMM_I: imm32 = $signed({{20{if_id_instruction[31]}}, if_id_instruction[31:20]});
      IMM_S: imm32 = $signed({{20{if_id_instruction[31]}}, if_id_instruction[31:25],
                              if_id_instruction[11:7]});
      IMM_B: imm32 = $signed({{19{if_id_instruction[31]}}, if_id_instruction[31],
                              if_id_instruction[7], if_id_instruction[30:25],
                              if_id_instruction[11:8], 1'b0});
      IMM_U: imm32 = $signed({if_id_instruction[31:12], 12'b0});
      IMM_J: imm32 = $signed({{11{if_id_instruction[31]}}, if_id_instruction[31],
                              if_id_instruction[19:12], if_id_instruction[20],
                              if_id_instruction[30:21], 1'b0});
      default: imm32 = '0;
    endcase
  end

  // Operand selection: x0 reads zero, a pending WB write to the same register wins
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (use_rs1 && rs1_field != 5'd0) begin
      if (WB_BYPASS && mem_wb_reg_write && mem_wb_rd_addr != 5'd0 && mem_wb_rd_addr == rs1_field)
        rs1_val = mem_wb_rd_data;
      else
        rs1_val = rs1_data;
    end
    if (use_rs2 && rs2_field != 5'd0) begin
      if (WB_BYPASS && mem_wb_reg_write && mem_wb_rd_addr != 5'd0 && mem_wb_rd_addr == rs2_field)
        rs2_val = mem_wb_rd_data;
      else
        rs2_val = rs2_data;
    end
  end

  // Fully decoded ID/EX candidate for the instruction currently in IF/ID
  always_comb begin
    dec           = '0;
    dec.pc        = if_id_pc;
    dec.instr     = if_id_instruction;
    dec.rs1_data  = rs1_val;
    dec.rs2_data  = rs2_val;
    dec.imm       = XLEN'(imm32);
    dec.rd_addr   = rd_zero ? 5'd0 : rd_field;
    dec.rs1_addr  = use_rs1 ? rs1_field : 5'd0;
    dec.rs2_addr  = use_rs2 ? rs2_field : 5'd0;
    dec.reg_write = ctl_reg_write;
    dec.mem_read  = ctl_mem_read;
    dec.mem_write = ctl_mem_write;
    dec.alu_src   = ctl_alu_src;
    dec.branch    = ctl_branch;
    dec.jump      = ctl_jump;
    dec.alu_op    = ctl_alu_op;
    dec.illegal   = ctl_illegal;
    dec.valid     = 1'b1;
  end

  // Load-use: the load in EX cannot supply data before this instruction needs it
  always_comb begin
    hazard = HAZARD_EN && idex_q.valid && idex_q.mem_read && idex_q.rd_addr != 5'd0 &&
             if_id_valid &&
             ((use_rs1 && rs1_field == idex_q.rd_addr) ||
              (use_rs2 && rs2_field == idex_q.rd_addr));
  end

  // A flush drains ID/EX regardless of stalls, so IF may always advance then
  assign id_ready = flush | ~(ex_stall | hazard);

  // ID/EX next state: flush, then stall hold, then load-use bubble, then capture
  always_comb begin
    idex_d = idex_q;
    cnt_d  = cnt_q;
    if (flush) begin
      idex_d = '0;
    end else if (ex_stall) begin
      idex_d = idex_q;
    end else if (hazard) begin
      idex_d = '0;
      if (cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
    end else if (!if_id_valid) begin
      idex_d = '0;
    end else begin
      idex_d = dec;
    end
  end

  // ID/EX pipeline register and hazard counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign id_ex_pc          = idex_q.pc;
  assign id_ex_instruction = idex_q.instr;
  assign id_ex_rs1_data    = idex_q.rs1_data;
  assign id_ex_rs2_data    = idex_q.rs2_data;
  assign id_ex_immediate   = idex_q.imm;
  assign id_ex_rd_addr     = idex_q.rd_addr;
  assign id_ex_rs1_addr    = idex_q.rs1_addr;
  assign id_ex_rs2_addr    = idex_q.rs2_addr;
  assign id_ex_reg_write   = idex_q.reg_write;
  assign id_ex_mem_read    = idex_q.mem_read;
  assign id_ex_mem_write   = idex_q.mem_write;
  assign id_ex_alu_src     = idex_q.alu_src;
  assign id_ex_branch      = idex_q.branch;
  assign id_ex_jump        = idex_q.jump;
  assign id_ex_alu_op      = idex_q.alu_op;
  assign id_ex_illegal     = idex_q.illegal;
  assign id_ex_valid       = idex_q.valid;
  assign hazard_count      = cnt_q;

endmodule
